// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer (FETCH/DECODE/IMM/EXEC/MEM/HALT).
// Outputs are a Moore decode of the state and the instruction latched in DECODE.
// Branch PS also depends on the live Z/N/Cout flags during EXEC.
// While clear is high every output is forced to 0 asynchronously.
// Optional feature macro: CTRL_STACK_EN enables PUSH/POP decode. When it is
// undefined, those sub-ops are NOPs and SS stays 00.
module control_sequencer #(
    parameter bit IMM_SEXT = 1'b1
) (
    input  logic        clock_50,
    input  logic        clear,
    input  logic [15:0] IR,
    input  logic        Z,
    input  logic        N,
    input  logic        Cout,
    output logic [1:0]  PS,
    output logic        IR_L,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    output logic [2:0]  DA,
    output logic        WR,
    output logic        MW,
    output logic        MA,
    output logic        Cin,
    output logic [4:0]  FS,
    output logic [4:0]  MD,
    output logic [1:0]  SS,
    output logic [15:0] k,
    output logic        halted
);

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_ABS  = 2'b11;
    localparam logic [4:0] MD_ALU  = 5'b00100;
    localparam logic [4:0] MD_MEM  = 5'b01000;
`ifdef CTRL_STACK_EN
    localparam logic [4:0] MD_STK  = 5'b10000;
    localparam logic [1:0] SS_PUSH = 2'b01;
    localparam logic [1:0] SS_POP  = 2'b10;
`endif
    localparam logic [4:0] FS_SUB  = 5'b10110;
    localparam logic [4:0] FS_NEG  = 5'b10011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_IMM    = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        active;
    logic [15:0] instr_q;

    logic [1:0]  cls_d;
    logic [2:0]  sub_d;
    logic [1:0]  cls_q;
    logic [2:0]  sub_q;
    logic        mem_op;
    logic [15:0] imm_word;

    assign cls_d = IR[15:14];
    assign sub_d = IR[13:11];
    assign cls_q = instr_q[15:14];
    assign sub_q = instr_q[13:11];

    // Narrow immediates keep only the low byte.
    assign imm_word = IMM_SEXT ? IR : {8'h00, IR[7:0]};

    // Instructions that need a MEM writeback cycle after EXEC.
`ifdef CTRL_STACK_EN
    assign mem_op = (cls_q == 2'b10) && ((sub_q == 3'b001) || (sub_q == 3'b011));
`else
    assign mem_op = (cls_q == 2'b10) && (sub_q == 3'b001);
`endif

    // State register; 'active' holds the FSM idle at FETCH for the first edge after clear.
    always_ff @(posedge clock_50 or posedge clear) begin
        if (clear) begin
            state   <= S_FETCH;
            active  <= 1'b0;
            instr_q <= 16'h0000;
        end else begin
            active <= 1'b1;
            state  <= state_d;
            if (active && (state == S_DECODE)) begin
                instr_q <= IR;
            end
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d = state;
        PS      = PS_HOLD;
        IR_L    = 1'b0;
        AA      = 3'b000;
        BA      = 3'b000;
        DA      = 3'b000;
        WR      = 1'b0;
        MW      = 1'b0;
        MA      = 1'b0;
        Cin     = 1'b0;
        FS      = 5'b00000;
        MD      = 5'b00000;
        SS      = 2'b00;
        k       = 16'h0000;
        halted  = 1'b0;

        if (!active) begin
            state_d = S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    IR_L    = 1'b1;
                    PS      = PS_INC;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if ((cls_d == 2'b01) || ((cls_d == 2'b11) && (sub_d <= 3'b011))) begin
                        state_d = S_IMM;
                    end else if ((cls_d == 2'b11) && (sub_d == 3'b111)) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_IMM: begin
                    IR_L    = 1'b1;
                    PS      = PS_INC;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = mem_op ? S_MEM : S_FETCH;
                    case (cls_q)
                        2'b00, 2'b01: begin
                            FS  = instr_q[13:9];
                            DA  = instr_q[8:6];
                            AA  = instr_q[5:3];
                            BA  = instr_q[2:0];
                            WR  = 1'b1;
                            MD  = MD_ALU;
                            Cin = (instr_q[13:9] == FS_SUB) || (instr_q[13:9] == FS_NEG);
                            if (cls_q == 2'b01) begin
                                MA = 1'b1;
                                k  = imm_word;
                            end
                        end
                        2'b10: begin
                            case (sub_q)
                                3'b000: begin
                                    MW = 1'b1;
                                    AA = instr_q[5:3];
                                    BA = instr_q[2:0];
                                end
                                3'b001: AA = instr_q[5:3];
`ifdef CTRL_STACK_EN
                                3'b010: begin
                                    SS = SS_PUSH;
                                    BA = instr_q[2:0];
                                end
                                3'b011: SS = SS_POP;
`endif
                                default: ;
                            endcase
                        end
                        default: begin
                            case (sub_q)
                                3'b000, 3'b001, 3'b010: begin
                                    if (((sub_q == 3'b000) && Z) ||
                                        ((sub_q == 3'b001) && N) ||
                                        ((sub_q == 3'b010) && Cout)) begin
                                        PS = PS_REL;
                                        k  = IR;
                                    end
                                end
                                3'b011: begin
                                    PS = PS_ABS;
                                    AA = instr_q[5:3];
                                end
                                default: ;
                            endcase
                        end
                    endcase
                end
                S_MEM: begin
                    state_d = S_FETCH;
                    WR      = 1'b1;
                    DA      = instr_q[8:6];
`ifdef CTRL_STACK_EN
                    MD      = (sub_q == 3'b001) ? MD_MEM : MD_STK;
`else
                    MD      = MD_MEM;
`endif
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instructions against a phase-list model.
// Two instances run side by side: IMM_SEXT=1 and IMM_SEXT=0.
module tb_control_sequencer;

`ifdef CTRL_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_I = 2;
    localparam int PH_X = 3;
    localparam int PH_M = 4;
    localparam int PH_H = 5;

    logic        clock_50;
    logic        clear;
    logic [15:0] IR;
    logic        Z, N, Cout;

    logic [1:0]  ps_s, ps_z, ss_s, ss_z;
    logic        irl_s, irl_z, wr_s, wr_z, mw_s, mw_z, ma_s, ma_z, cin_s, cin_z, hl_s, hl_z;
    logic [2:0]  aa_s, aa_z, ba_s, ba_z, da_s, da_z;
    logic [4:0]  fs_s, fs_z, md_s, md_z;
    logic [15:0] k_s, k_z;
    logic [44:0] word_s, word_z;

    int n_cmp = 0;
    int n_err = 0;

    control_sequencer #(.IMM_SEXT(1'b1)) dut_s (
        .clock_50(clock_50), .clear(clear), .IR(IR), .Z(Z), .N(N), .Cout(Cout),
        .PS(ps_s), .IR_L(irl_s), .AA(aa_s), .BA(ba_s), .DA(da_s),
        .WR(wr_s), .MW(mw_s), .MA(ma_s), .Cin(cin_s),
        .FS(fs_s), .MD(md_s), .SS(ss_s), .k(k_s), .halted(hl_s)
    );

    control_sequencer #(.IMM_SEXT(1'b0)) dut_z (
        .clock_50(clock_50), .clear(clear), .IR(IR), .Z(Z), .N(N), .Cout(Cout),
        .PS(ps_z), .IR_L(irl_z), .AA(aa_z), .BA(ba_z), .DA(da_z),
        .WR(wr_z), .MW(mw_z), .MA(ma_z), .Cin(cin_z),
        .FS(fs_z), .MD(md_z), .SS(ss_z), .k(k_z), .halted(hl_z)
    );

    assign word_s = {ps_s, irl_s, aa_s, ba_s, da_s, wr_s, mw_s, ma_s, cin_s, fs_s, md_s, ss_s, k_s, hl_s};
    assign word_z = {ps_z, irl_z, aa_z, ba_z, da_z, wr_z, mw_z, ma_z, cin_z, fs_z, md_z, ss_z, k_z, hl_z};

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [44:0] got, input logic [44:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Instruction timing rules: which optional phases an instruction passes through.
    function automatic bit needs_imm(input logic [15:0] ins);
        return (ins[15:14] == 2'b01) || ((ins[15:14] == 2'b11) && (ins[13:11] <= 3'b011));
    endfunction

    function automatic bit needs_mem(input logic [15:0] ins);
        return (ins[15:14] == 2'b10) && ((ins[13:11] == 3'b001) || (STACK && ins[13:11] == 3'b011));
    endfunction

    function automatic bit is_halt(input logic [15:0] ins);
        return ins[15:11] == 5'b11111;
    endfunction

    // Halt is observed for FETCH, DECODE and ten HALT cycles.
    function automatic int n_phases(input logic [15:0] ins);
        if (is_halt(ins)) return 12;
        if (needs_imm(ins) || needs_mem(ins)) return 4;
        return 3;
    endfunction

    function automatic int phase_at(input logic [15:0] ins, input int idx);
        if (idx == 0) return PH_F;
        if (idx == 1) return PH_D;
        if (is_halt(ins)) return PH_H;
        if (needs_imm(ins)) return (idx == 2) ? PH_I : PH_X;
        if (needs_mem(ins)) return (idx == 2) ? PH_X : PH_M;
        return PH_X;
    endfunction

    // Expected output word for one phase of an instruction.
    function automatic logic [44:0] exp_word(input logic [15:0] ins, input int ph,
                                             input logic [15:0] imm, input logic [2:0] f,
                                             input bit sext);
        logic [1:0]  ps, ss;
        logic        irl, wr, mw, ma, cin, hl, taken;
        logic [2:0]  aa, ba, da, sub;
        logic [4:0]  fs, md;
        logic [15:0] kk;
        ps = 0; ss = 0; irl = 0; wr = 0; mw = 0; ma = 0; cin = 0; hl = 0;
        aa = 0; ba = 0; da = 0; fs = 0; md = 0; kk = 0; taken = 0;
        sub = ins[13:11];
        case (ph)
            PH_F, PH_I: begin irl = 1; ps = 2'b01; end
            PH_H: hl = 1;
            PH_M: begin
                wr = 1;
                da = ins[8:6];
                md = (sub == 3'b001) ? 5'd8 : 5'd16;
            end
            PH_X: begin
                if (ins[15] == 1'b0) begin
                    fs = ins[13:9]; da = ins[8:6]; aa = ins[5:3]; ba = ins[2:0];
                    wr = 1; md = 5'd4;
                    cin = (fs == 5'd22) || (fs == 5'd19);
                    if (ins[14]) begin
                        ma = 1;
                        kk = sext ? imm : {8'h00, imm[7:0]};
                    end
                end else if (ins[14] == 1'b0) begin
                    if (sub == 3'd0) begin mw = 1; aa = ins[5:3]; ba = ins[2:0]; end
                    if (sub == 3'd1) aa = ins[5:3];
                    if (STACK && sub == 3'd2) begin ss = 2'b01; ba = ins[2:0]; end
                    if (STACK && sub == 3'd3) ss = 2'b10;
                end else begin
                    if (sub <= 3'd2) begin
                        taken = f[2 - int'(sub)];
                        ps = taken ? 2'b10 : 2'b00;
                        kk = taken ? imm : 16'h0000;
                    end
                    if (sub == 3'd3) begin ps = 2'b11; aa = ins[5:3]; end
                end
            end
            default: ;
        endcase
        return {ps, irl, aa, ba, da, wr, mw, ma, cin, fs, md, ss, kk, hl};
    endfunction

    // Runs one instruction; flags < 0 means random Z/N/Cout each cycle, else {Z,N,Cout}.
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] imm, input int flags);
        int ph;
        logic [2:0] fl;
        for (int i = 0; i < n_phases(ins); i++) begin
            @(negedge clock_50);
            ph = phase_at(ins, i);
            if (ph == PH_D) IR = ins;
            else if (ph == PH_X && needs_imm(ins)) IR = imm;
            else IR = 16'($urandom);
            fl = (flags < 0) ? 3'($urandom) : 3'(flags);
            {Z, N, Cout} = fl;
            #1;
            check($sformatf("sext ins=%h ph=%0d", ins, ph), word_s, exp_word(ins, ph, imm, fl, 1'b1));
            check($sformatf("zext ins=%h ph=%0d", ins, ph), word_z, exp_word(ins, ph, imm, fl, 1'b0));
        end
    endtask

    // Asserts clear mid-cycle, checks immediate and held zeros, then releases it.
    task automatic do_clear(input string tag);
        #1 clear = 1'b1;
        #1;
        check({tag, " async s"}, word_s, 45'd0);
        check({tag, " async z"}, word_z, 45'd0);
        @(negedge clock_50);
        check({tag, " held s"}, word_s, 45'd0);
        clear = 1'b0;
        #1;
        check({tag, " pending s"}, word_s, 45'd0);
        check({tag, " pending z"}, word_z, 45'd0);
    endtask

    initial begin
        logic [15:0] ins;
        clear = 1'b1;
        IR = 16'hFFFF;
        {Z, N, Cout} = 3'b111;
        repeat (2) @(negedge clock_50);
        check("reset s", word_s, 45'd0);
        check("reset z", word_z, 45'd0);
        clear = 1'b0;
        #1;
        check("release s", word_s, 45'd0);
        check("release z", word_z, 45'd0);

        run_instr(16'h0000, 16'h0000, -1);
        run_instr(16'h5400, 16'h000F, -1);
        run_instr(16'h6C00, 16'hABCD, -1);
        run_instr(16'h2C00, 16'h0000, -1);
        run_instr(16'h2600, 16'h0000, -1);
        run_instr(16'hC000, 16'h0004, 3'b100);
        run_instr(16'hC000, 16'h0004, 3'b011);
        run_instr(16'hC800, 16'h0123, 3'b010);
        run_instr(16'hD000, 16'h8001, 3'b001);
        run_instr(16'hD828, 16'h0000, -1);
        run_instr(16'h8850, 16'h0000, -1);
        run_instr(16'h8013, 16'h0000, -1);
        run_instr(16'h9005, 16'h0000, -1);
        run_instr(16'h9840, 16'h0000, -1);
        run_instr(16'hA1FF, 16'h0000, -1);
        run_instr(16'hE1FF, 16'h0000, -1);

        for (int i = 0; i < 200; i++) begin
            ins = 16'($urandom);
            if (ins[15:11] == 5'b11111) ins[13:11] = 3'b100;
            run_instr(ins, 16'($urandom), -1);
        end

        run_instr(16'hF800, 16'h0000, -1);
        do_clear("halt exit");
        run_instr(16'h0241, 16'h0000, -1);

        run_instr(16'h8850, 16'h0000, -1);
        do_clear("ldi abort");
        run_instr(16'h9AC0, 16'h0000, -1);
        do_clear("pop abort");
        run_instr(16'h5400, 16'h000F, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter IMM_SEXT, default 1, meaning the 16-bit immediate word is passed to k unchanged when 1 and with bits [15:8] forced to 0 when 0.
REQ-002 The block SHALL have port clock_50  input  1  system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port clear  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port IR  input  16  current instruction-register contents from the datapath.
REQ-005 The block SHALL have ports Z, N, Cout  input  1 each  datapath status flags.
REQ-006 The block SHALL have port PS  output  2  PC control: 00 hold, 01 increment, 10 PC+k, 11 PC<=A bus.
REQ-007 The block SHALL have port IR_L  output  1  IR load strobe.
REQ-008 The block SHALL have ports AA, BA, DA  output  3 each  register-file A, B and destination addresses.
REQ-009 The block SHALL have ports WR, MW, MA, Cin  output  1 each  register write, memory write, constant-to-B select and ALU carry-in.
REQ-010 The block SHALL have ports FS (5), MD (5), SS (2) and k (16), all outputs: ALU function, writeback source (00100 ALU, 01000 memory, 10000 stack), stack op (01 push, 10 pop) and constant.
REQ-011 The block SHALL have port halted  output  1  high while in the HALT state.

Function
REQ-012 FSM states SHALL be FETCH, DECODE, IMM, EXEC, MEM and HALT, one state per clock.
REQ-013 Transitions SHALL be: FETCH->DECODE; DECODE->IMM for class 01 or branch/JMP, ->HALT for HALT, ->EXEC otherwise; IMM->EXEC; EXEC->MEM for LDI/POP, else ->FETCH; MEM->FETCH; HALT->HALT.
REQ-014 FETCH and IMM SHALL drive IR_L=1 and PS=01 with WR=MW=0 and SS=00.
REQ-015 DECODE SHALL latch IR into an internal instruction register, and every EXEC/MEM field SHALL come from that latched copy.
REQ-016 Outside EXEC/MEM all other outputs SHALL be 0 (NOP word), and outputs SHALL be Moore-decoded from state plus the latched instruction.
REQ-017 Instruction class SHALL be IR[15:14]; for classes 00/01, FS=IR[13:9], DA=IR[8:6], AA=IR[5:3], BA=IR[2:0].
REQ-018 Class 00 EXEC SHALL drive WR=1, MD=00100, MA=0.
REQ-019 Class 01 EXEC SHALL drive WR=1, MD=00100, MA=1, k=IR input (the immediate word, extended per IMM_SEXT).
REQ-020 Cin SHALL be 1 iff FS is 10110 (SUB) or 10011 (NEG).
REQ-021 Class 10 sub-ops (IR[13:11]) SHALL be: 000 STI: MW=1, address AA, data BA; 001 LDI: EXEC address AA, MEM WR=1, MD=01000, DA; 010 PUSH: SS=01, BA, WR=0; 011 POP: EXEC SS=10, MEM WR=1, MD=10000, DA.
REQ-022 Class 11 sub-ops SHALL be: 000 BRZ, 001 BRN, 010 BRC, taking PS=10 with k=offset word iff Z, N or Cout respectively =1 in EXEC, else PS=00; 011 JMP: PS=11, AA=IR[5:3]; 111 HALT.
REQ-023 Unused sub-ops SHALL execute as a one-cycle NOP EXEC with no write strobe.
REQ-024 WR, MW and SS!=00 SHALL never be asserted in the same cycle as IR_L=1.
REQ-025 Latency SHALL be: class 00 = 3 cycles; class 01, branch and JMP = 4; LDI/POP = 4; STI/PUSH = 3.

Reset
REQ-026 While clear=1, state SHALL be FETCH-pending (held inactive), all outputs 0, halted=0, and the internal instruction register 0.
REQ-027 On the first rising edge after clear deasserts, the state SHALL be FETCH.
REQ-028 Assertion of clear mid-instruction SHALL abort it immediately with no further WR/MW/SS pulse, and clear SHALL be the only exit from HALT.

Configuration
REQ-029 When CTRL_STACK_EN is defined, PUSH/POP SHALL decode per REQ-021; when it is undefined, sub-ops 010/011 SHALL behave as NOP per REQ-023, SS SHALL be tied to 00, and MD SHALL never equal 10000.

Verification
REQ-030 Release clear, IR=0x0000 in FETCH -> DECODE, then EXEC with WR=1, FS=00000, MD=00100, then FETCH, 3 cycles total.
REQ-031 ALU-imm 0x5400 (FS=01010, DA=0) followed by word 0x000F -> IMM pulses IR_L, and EXEC shows MA=1, k=0x000F, WR=1.
REQ-032 BRZ with Z=1 and offset 0x0004 -> EXEC PS=10, k=0x0004; with Z=0 -> PS=00.
REQ-033 LDI with AA=2, DA=1 -> EXEC WR=0, MEM WR=1, MD=01000, DA=1, then FETCH.
REQ-034 HALT opcode -> halted=1 held for 10 cycles with all strobes 0; pulsing clear -> outputs 0 and FETCH resumes.
REQ-035 Assert clear during MEM of POP -> no WR pulse, all outputs 0 asynchronously.
